// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall / flush / PC-select controller for a 5-stage pipeline.
//                Resolves data-memory wait states, EX-stage taken branches,
//                load-use hazards, ID-stage jumps and instruction-fetch wait
//                states. Includes a memory watchdog with a sticky error and
//                free-running stall / flush statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic [1:0]       pc_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wait counter only needs to reach TIMEOUT.
  localparam int                  c_WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT_V = c_WAIT_W'(TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] c_SEL_PC4    = 2'd0;
  localparam logic [1:0] c_SEL_BRANCH = 2'd1;
  localparam logic [1:0] c_SEL_JUMP   = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_IWAIT = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_inc;
  logic                w_waiting;
  logic                r_mem_timeout;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic                w_load_use;
  logic                w_dfreeze;
  logic                w_redirect;

  // Results of the normal-flow rules (branch, load-use, jump, fetch miss).
  logic                w_rn_pc_stall;
  logic                w_rn_ifid_stall;
  logic                w_rn_ifid_flush;
  logic                w_rn_idex_flush;
  logic [1:0]          w_rn_pc_sel;
  logic                w_rn_fetch_miss;

  // Final (ungated) control values.
  logic                w_pc_stall;
  logic                w_ifid_stall;
  logic                w_ifid_flush;
  logic                w_idex_stall;
  logic                w_idex_flush;
  logic                w_exmem_stall;
  logic [1:0]          w_pc_sel;

  // A load in EX writing a register (not $0) that the ID instruction reads.
  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

  // Data access outstanding: the whole front of the pipe must freeze.
  assign w_dfreeze  = mem_req && !dmem_ready;

  // A redirect that actually takes effect; a jump blocked by a load-use
  // stall is not applied this cycle.
  assign w_redirect = ex_branch_taken || (id_jump && !w_load_use);

  // Normal-flow priority: branch (oldest) > load-use > jump > fetch miss.
  always_comb begin
    w_rn_pc_stall   = 1'b0;
    w_rn_ifid_stall = 1'b0;
    w_rn_ifid_flush = 1'b0;
    w_rn_idex_flush = 1'b0;
    w_rn_pc_sel     = c_SEL_PC4;
    w_rn_fetch_miss = 1'b0;
    if (ex_branch_taken) begin
      w_rn_ifid_flush = 1'b1;
      w_rn_idex_flush = 1'b1;
      w_rn_pc_sel     = c_SEL_BRANCH;
    end else if (w_load_use) begin
      w_rn_pc_stall   = 1'b1;
      w_rn_ifid_stall = 1'b1;
      w_rn_idex_flush = 1'b1;
    end else if (id_jump) begin
      w_rn_ifid_flush = 1'b1;
      w_rn_pc_sel     = c_SEL_JUMP;
    end else if (!imem_ready) begin
      w_rn_pc_stall   = 1'b1;
      w_rn_ifid_flush = 1'b1;
      w_rn_fetch_miss = 1'b1;
    end
  end

  // State-dependent selection of the controls and the next state.
  always_comb begin
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_stall  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_stall = 1'b0;
    w_pc_sel      = c_SEL_PC4;
    w_next_state  = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_dfreeze) begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_stall  = 1'b1;
          w_exmem_stall = 1'b1;
          w_next_state  = ST_DWAIT;
        end else begin
          w_pc_stall   = w_rn_pc_stall;
          w_ifid_stall = w_rn_ifid_stall;
          w_ifid_flush = w_rn_ifid_flush;
          w_idex_flush = w_rn_idex_flush;
          w_pc_sel     = w_rn_pc_sel;
          w_next_state = w_rn_fetch_miss ? ST_IWAIT : ST_RUN;
        end
      end
      ST_DWAIT: begin
        if (!dmem_ready) begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_stall  = 1'b1;
          w_exmem_stall = 1'b1;
        end else begin
          w_pc_stall   = w_rn_pc_stall;
          w_ifid_stall = w_rn_ifid_stall;
          w_ifid_flush = w_rn_ifid_flush;
          w_idex_flush = w_rn_idex_flush;
          w_pc_sel     = w_rn_pc_sel;
          w_next_state = ST_RUN;
        end
      end
      ST_IWAIT: begin
        if (w_dfreeze) begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_stall  = 1'b1;
          w_exmem_stall = 1'b1;
          w_next_state  = ST_DWAIT;
        end else begin
          w_pc_stall   = w_rn_pc_stall;
          w_ifid_stall = w_rn_ifid_stall;
          w_ifid_flush = w_rn_ifid_flush;
          w_idex_flush = w_rn_idex_flush;
          w_pc_sel     = w_rn_pc_sel;
          // A redirect restarts fetch at the target, abandoning the miss.
          w_next_state = (!imem_ready && !w_redirect) ? ST_IWAIT : ST_RUN;
        end
      end
      ST_ERR: begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_stall  = 1'b1;
        w_exmem_stall = 1'b1;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // Still waiting on the same memory next cycle -> watchdog keeps counting.
  assign w_waiting  = ((r_state == ST_DWAIT) || (r_state == ST_IWAIT)) &&
                      (w_next_state == r_state);
  assign w_wait_inc = r_wait_cnt + c_WAIT_ONE;

  // State register and memory watchdog; the error state is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else if (w_waiting) begin
      r_wait_cnt <= w_wait_inc;
      if (w_wait_inc == c_TIMEOUT_V) begin
        r_state       <= ST_ERR;
        r_mem_timeout <= 1'b1;
      end else begin
        r_state <= w_next_state;
      end
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= '0;
    end
  end

  // Controls are forced quiet for the whole time reset is held.
  assign pc_stall    = !reset && w_pc_stall;
  assign ifid_stall  = !reset && w_ifid_stall;
  assign ifid_flush  = !reset && w_ifid_flush;
  assign idex_stall  = !reset && w_idex_stall;
  assign idex_flush  = !reset && w_idex_flush;
  assign exmem_stall = !reset && w_exmem_stall;
  assign pc_sel      = reset ? c_SEL_PC4 : w_pc_sel;

  // Statistics: count stall and flush cycles, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_stall) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (ifid_flush) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl. Two
//                instances share stimulus: a default build and a small build
//                (TIMEOUT=4, CNT_W=4) exercising watchdog and counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_jump, ex_mem_read;
  logic       ex_branch_taken, imem_ready, mem_req, dmem_ready;

  logic        pc_stall_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_flush_a, exmem_stall_a;
  logic [1:0]  pc_sel_a;
  logic        mem_timeout_a;
  logic [31:0] stall_cnt_a, flush_cnt_a;

  logic        pc_stall_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_flush_b, exmem_stall_b;
  logic [1:0]  pc_sel_b;
  logic        mem_timeout_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;

  // Control vector layout: {pc_stall, ifid_stall, ifid_flush, idex_stall,
  //                         idex_flush, exmem_stall, pc_sel[1:0]}
  logic [7:0] ctrl_a, ctrl_b;
  assign ctrl_a = {pc_stall_a, ifid_stall_a, ifid_flush_a, idex_stall_a,
                   idex_flush_a, exmem_stall_a, pc_sel_a};
  assign ctrl_b = {pc_stall_b, ifid_stall_b, ifid_flush_b, idex_stall_b,
                   idex_flush_b, exmem_stall_b, pc_sel_b};

  localparam logic [7:0] c_NONE  = 8'b000000_00;
  localparam logic [7:0] c_LU    = 8'b110010_00;
  localparam logic [7:0] c_BR    = 8'b001010_01;
  localparam logic [7:0] c_JMP   = 8'b001000_10;
  localparam logic [7:0] c_IMISS = 8'b101000_00;
  localparam logic [7:0] c_FRZ   = 8'b110101_00;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall_a), .ifid_stall(ifid_stall_a), .ifid_flush(ifid_flush_a),
    .idex_stall(idex_stall_a), .idex_flush(idex_flush_a), .exmem_stall(exmem_stall_a),
    .pc_sel(pc_sel_a), .mem_timeout(mem_timeout_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall_b), .ifid_stall(ifid_stall_b), .ifid_flush(ifid_flush_b),
    .idex_stall(idex_stall_b), .idex_flush(idex_flush_b), .exmem_stall(exmem_stall_b),
    .pc_sel(pc_sel_b), .mem_timeout(mem_timeout_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] ea;
    logic [7:0] eb;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   exp_st_a, exp_fl_a, exp_st_b, exp_fl_b;
  logic exp_tmo_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_jump = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
    imem_ready = 1'b1; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // One cycle: expectation queued with the stimulus, controls compared
  // mid-cycle, then counters and watchdog compared just after the edge.
  task automatic step(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    sb.push_back('{tag: tag, ea: ea, eb: eb});
    #2;
    e = sb.pop_front();
    chk({e.tag, " ctrl_a"}, 32'(ctrl_a), 32'(e.ea));
    chk({e.tag, " ctrl_b"}, 32'(ctrl_b), 32'(e.eb));
    @(posedge clk);
    #1;
    if (e.ea[7]) exp_st_a++;
    if (e.ea[5]) exp_fl_a++;
    if (e.eb[7]) exp_st_b++;
    if (e.eb[5]) exp_fl_b++;
    chk({e.tag, " stall_cnt_a"}, stall_cnt_a, 32'(exp_st_a));
    chk({e.tag, " flush_cnt_a"}, flush_cnt_a, 32'(exp_fl_a));
    chk({e.tag, " stall_cnt_b"}, 32'(stall_cnt_b), 32'(exp_st_b % 16));
    chk({e.tag, " flush_cnt_b"}, 32'(flush_cnt_b), 32'(exp_fl_b % 16));
    chk({e.tag, " timeout_a"}, 32'(mem_timeout_a), 32'd0);
    chk({e.tag, " timeout_b"}, 32'(mem_timeout_b), 32'(exp_tmo_b));
    @(negedge clk);
  endtask

  initial begin
    exp_st_a = 0; exp_fl_a = 0; exp_st_b = 0; exp_fl_b = 0; exp_tmo_b = 1'b0;
    reset = 1'b1;
    clr();
    // Reset held with aggressive inputs: controls must stay quiet.
    ex_branch_taken = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b0;
    step("reset_hold", c_NONE, c_NONE);
    reset = 1'b0;
    clr(); step("idle", c_NONE, c_NONE);

    // Load-use hazards.
    clr(); ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    step("lu_rs", c_LU, c_LU);
    clr(); step("lu_next", c_NONE, c_NONE);
    clr(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    step("lu_rd0", c_NONE, c_NONE);
    clr(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    id_rs = 5'd3; id_uses_rs = 1'b1;
    step("lu_rt", c_LU, c_LU);
    clr(); ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b0;
    step("lu_unused", c_NONE, c_NONE);
    clr(); ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    step("no_load", c_NONE, c_NONE);

    // Branch beats load-use and jump; load-use beats jump.
    clr(); ex_branch_taken = 1'b1; id_jump = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    step("br_all", c_BR, c_BR);
    clr(); id_jump = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    step("lu_over_jmp", c_LU, c_LU);
    clr(); id_jump = 1'b1;
    step("jump", c_JMP, c_JMP);
    clr(); id_jump = 1'b1; imem_ready = 1'b0;
    step("jmp_over_miss", c_JMP, c_JMP);
    clr(); step("after_jmp", c_NONE, c_NONE);

    // Data-memory wait: 3 freeze cycles, then release.
    clr(); mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    step("dwait_1", c_FRZ, c_FRZ);
    clr(); mem_req = 1'b1; dmem_ready = 1'b0;
    step("dwait_2", c_FRZ, c_FRZ);
    step("dwait_3", c_FRZ, c_FRZ);
    dmem_ready = 1'b1;
    step("dwait_rel", c_NONE, c_NONE);
    clr(); step("dwait_run", c_NONE, c_NONE);
    clr(); mem_req = 1'b1; dmem_ready = 1'b0;
    step("dwait2_1", c_FRZ, c_FRZ);
    dmem_ready = 1'b1; ex_branch_taken = 1'b1;
    step("dwait2_br", c_BR, c_BR);
    clr(); step("dwait2_run", c_NONE, c_NONE);

    // Instruction-fetch wait with jump / branch redirects.
    clr(); imem_ready = 1'b0;
    step("iwait_1", c_IMISS, c_IMISS);
    id_jump = 1'b1;
    step("iwait_jmp", c_JMP, c_JMP);
    clr(); step("iwait_run", c_NONE, c_NONE);
    clr(); imem_ready = 1'b0;
    step("iwait2_1", c_IMISS, c_IMISS);
    ex_branch_taken = 1'b1;
    step("iwait2_br", c_BR, c_BR);
    clr(); imem_ready = 1'b0;
    step("iwait3_1", c_IMISS, c_IMISS);
    mem_req = 1'b1; dmem_ready = 1'b0;
    step("iwait3_dfrz", c_FRZ, c_FRZ);
    dmem_ready = 1'b1; imem_ready = 1'b1;
    step("iwait3_rel", c_NONE, c_NONE);
    clr(); step("iwait3_run", c_NONE, c_NONE);

    // Repeated stalls push the 4-bit stall counter through its wrap.
    for (int i = 0; i < 16; i++) begin
      clr(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
      step("wrap_lu", c_LU, c_LU);
    end
    clr(); step("wrap_done", c_NONE, c_NONE);

    // Watchdog: small build times out after 4 wait cycles in DWAIT.
    clr(); mem_req = 1'b1; dmem_ready = 1'b0;
    step("tmo_run", c_FRZ, c_FRZ);
    step("tmo_w1", c_FRZ, c_FRZ);
    step("tmo_w2", c_FRZ, c_FRZ);
    step("tmo_w3", c_FRZ, c_FRZ);
    exp_tmo_b = 1'b1;
    step("tmo_w4", c_FRZ, c_FRZ);
    clr();
    step("tmo_err_hold", c_NONE, c_FRZ);
    ex_branch_taken = 1'b1;
    step("tmo_err_br", c_BR, c_FRZ);

    // Reset clears error, state and statistics.
    clr(); reset = 1'b1;
    exp_st_a = 0; exp_fl_a = 0; exp_st_b = 0; exp_fl_b = 0; exp_tmo_b = 1'b0;
    step("rst2_hold", c_NONE, c_NONE);
    reset = 1'b0;
    step("rst2_idle", c_NONE, c_NONE);
    clr(); id_jump = 1'b1;
    step("rst2_jmp", c_JMP, c_JMP);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
